// File: rtl/full_handshake_tx_fifo.sv
// Buffered four-phase (req/ack) CDC sender: a DEPTH-entry FIFO drained one word per handshake.
// Optional sticky handshake timeout is built only when HS_TX_TIMEOUT_EN is defined.
module full_handshake_tx_fifo #(
  parameter int DW             = 32,
  parameter int DEPTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ack_i,
  input  logic                       req_i,
  input  logic [DW-1:0]              req_data_i,
  output logic                       ready_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       idle_o,
  output logic                       req_o,
  output logic [DW-1:0]              req_data_o,
  output logic                       timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (SYNC_STAGES < 2) begin : gBadSync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ASSERT   = 3'b010,
    DEASSERT = 3'b100
  } state_e;

  state_e                 state_q;
  logic                   req_q;
  logic [DW-1:0]          reqData_q;
  logic [SYNC_STAGES-1:0] ackSync_q;
  logic                   ackSynced;
  logic [DW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wrPtr_q, wrPtr_d;
  logic [AW-1:0]          rdPtr_q, rdPtr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   push;
  logic                   pop;

  // ack_i is asynchronous to clk_i; only the last stage is ever looked at.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ackSync_q <= '0;
    end else begin
      ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ackSynced = ackSync_q[SYNC_STAGES-1];

  assign push = req_i && ready_o;
  assign pop  = (state_q == IDLE) && (level_q != '0) && !ackSynced;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= req_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      reqData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            req_q     <= 1'b1;
            reqData_q <= mem_q[rdPtr_q];
            state_q   <= ASSERT;
          end
        end
        ASSERT: begin
          if (ackSynced) begin
            req_q     <= 1'b0;
            reqData_q <= '0;
            state_q   <= DEASSERT;
          end
        end
        DEASSERT: begin
          if (!ackSynced) begin
            state_q <= IDLE;
          end
        end
        default: begin
          req_q     <= 1'b0;
          reqData_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_o      = req_q;
  assign req_data_o = reqData_q;
  assign level_o    = level_q;
  assign ready_o    = level_q < FULL_LEVEL;
  assign idle_o     = (level_q == '0) && (state_q == IDLE) && !ackSynced;

`ifdef HS_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] toCount_q, toCount_d;
  logic          timeout_q;

  // Saturating count of cycles spent outside IDLE; the handshake itself is never aborted.
  always_comb begin
    toCount_d = toCount_q;
    if (state_q == IDLE) begin
      toCount_d = '0;
    end else if (toCount_q != TIMEOUT_LIMIT) begin
      toCount_d = toCount_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      toCount_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      toCount_q <= toCount_d;
      if (toCount_d == TIMEOUT_LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_full_handshake_tx_fifo.sv
// Directed bench for full_handshake_tx_fifo: table-driven burst fill plus hand-written
// handshake, reset, wrap and timeout sequences against a bench-side expected-word queue.
module tb_full_handshake_tx_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
`ifdef HS_TX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ackI = 1'b0;
  logic          reqI = 1'b0;
  logic [DW-1:0] reqDataI = '0;
  logic          readyO;
  logic [2:0]    levelO;
  logic          idleO;
  logic          reqO;
  logic [DW-1:0] reqDataO;
  logic          timeoutO;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] expQ [$];

  full_handshake_tx_fifo #(
    .DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ack_i(ackI), .req_i(reqI), .req_data_i(reqDataI),
    .ready_o(readyO), .level_o(levelO), .idle_o(idleO), .req_o(reqO),
    .req_data_o(reqDataO), .timeout_o(timeoutO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          reqI;
    logic [DW-1:0] dataI;
    logic          ackI;
    logic          expReq;
    logic [DW-1:0] expData;
    logic [2:0]    expLevel;
    logic          expReady;
    logic          expIdle;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reqI     = v.reqI;
    reqDataI = v.dataI;
    ackI     = v.ackI;
    tick();
    checkOutput($sformatf("vec%0d req_o", idx), DW'(reqO), DW'(v.expReq));
    checkOutput($sformatf("vec%0d req_data_o", idx), reqDataO, v.expData);
    checkOutput($sformatf("vec%0d level_o", idx), DW'(levelO), DW'(v.expLevel));
    checkOutput($sformatf("vec%0d ready_o", idx), DW'(readyO), DW'(v.expReady));
    checkOutput($sformatf("vec%0d idle_o", idx), DW'(idleO), DW'(v.expIdle));
  endtask

  task automatic doReset();
    rst = 1'b1;
    reqI = 1'b0;
    reqDataI = '0;
    ackI = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic waitReq(input logic level, input string name);
    int n = 0;
    while (reqO !== level && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkOutput({name, " wait timeout"}, DW'(reqO), DW'(level));
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (idleO !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, " idle_o"}, DW'(idleO), 32'd1);
    checkOutput({name, " level_o"}, DW'(levelO), 32'd0);
  endtask

  // Receiver model: completes n four-phase handshakes with random delays and scoreboards data.
  task automatic rxDrain(input int n, input int maxLat, input string name);
    logic [DW-1:0] exp;
    for (int k = 0; k < n; k++) begin
      waitReq(1'b1, name);
      if (expQ.size() == 0) begin
        checkOutput({name, " unexpected word"}, reqDataO, 32'hFFFF_FFFF);
        exp = reqDataO;
      end else begin
        exp = expQ.pop_front();
        checkOutput($sformatf("%s word%0d", name, k), reqDataO, exp);
      end
      repeat ($urandom_range(maxLat, 0)) tick();
      ackI = 1'b1;
      waitReq(1'b0, name);
      checkOutput($sformatf("%s data cleared %0d", name, k), reqDataO, 32'd0);
      repeat ($urandom_range(maxLat, 0)) tick();
      ackI = 1'b0;
    end
  endtask

  task automatic producer(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!readyO && guard < 500) begin
        tick();
        guard++;
      end
      if (guard >= 500) checkOutput("producer ready wait", DW'(readyO), 32'd1);
      reqI     = 1'b1;
      reqDataI = $urandom;
      expQ.push_back(reqDataI);
      tick();
      reqI = 1'b0;
      if ($urandom_range(1, 0) == 1) tick();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'hA0A0_0000, 1'b0, 1'b0, 32'h0,         3'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'hA0A0_0001, 1'b0, 1'b1, 32'hA0A0_0000, 3'd1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'hA0A0_0002, 1'b0, 1'b1, 32'hA0A0_0000, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'hA0A0_0003, 1'b0, 1'b1, 32'hA0A0_0000, 3'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'hA0A0_0004, 1'b0, 1'b1, 32'hA0A0_0000, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'hA0A0_0005, 1'b0, 1'b1, 32'hA0A0_0000, 3'd4, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hA0A0_0000, 3'd4, 1'b0, 1'b0};

    // Reset values, sampled while reset is still held.
    repeat (2) tick();
    checkOutput("reset req_o", DW'(reqO), 32'd0);
    checkOutput("reset req_data_o", reqDataO, 32'd0);
    checkOutput("reset level_o", DW'(levelO), 32'd0);
    checkOutput("reset ready_o", DW'(readyO), 32'd1);
    checkOutput("reset idle_o", DW'(idleO), 32'd1);
    checkOutput("reset timeout_o", DW'(timeoutO), 32'd0);
    rst = 1'b0;
    tick();

    // Single word: latency, synchroniser delay on both ack edges.
    reqI = 1'b1;
    reqDataI = 32'hDEAD_BEEF;
    tick();
    reqI = 1'b0;
    checkOutput("single level after push", DW'(levelO), 32'd1);
    checkOutput("single req before pop", DW'(reqO), 32'd0);
    tick();
    checkOutput("single req_o rise", DW'(reqO), 32'd1);
    checkOutput("single req_data_o", reqDataO, 32'hDEAD_BEEF);
    checkOutput("single level after pop", DW'(levelO), 32'd0);
    repeat (2) tick();
    ackI = 1'b1;
    repeat (2) tick();
    checkOutput("single req held during sync", DW'(reqO), 32'd1);
    tick();
    checkOutput("single req_o fall", DW'(reqO), 32'd0);
    checkOutput("single data cleared", reqDataO, 32'd0);
    ackI = 1'b0;
    repeat (2) tick();
    checkOutput("single idle during deassert", DW'(idleO), 32'd0);
    tick();
    checkOutput("single idle after ack low", DW'(idleO), 32'd1);

    // Burst into a stalled sender: fill, drop when full, then drain in order.
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);
    for (int i = 0; i < 5; i++) expQ.push_back(32'hA0A0_0000 + 32'(i));
    rxDrain(5, 2, "burst");
    waitIdle("burst");
    repeat (4) tick();
    checkOutput("burst no extra word", DW'(reqO), 32'd0);

    // Reset during ASSERT with ack high, then stale ack must hold off the next handshake.
    reqI = 1'b1;
    reqDataI = 32'h5555_AAAA;
    tick();
    reqI = 1'b0;
    tick();
    ackI = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst req_o async drop", DW'(reqO), 32'd0);
    checkOutput("rst level cleared", DW'(levelO), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("stale ack idle_o", DW'(idleO), 32'd0);
    reqI = 1'b1;
    reqDataI = 32'hC0DE_0001;
    tick();
    reqDataI = 32'hC0DE_0002;
    tick();
    reqI = 1'b0;
    repeat (2) tick();
    checkOutput("stale ack level", DW'(levelO), 32'd2);
    checkOutput("stale ack no req", DW'(reqO), 32'd0);
    ackI = 1'b0;
    repeat (2) tick();
    checkOutput("ack syncing no req", DW'(reqO), 32'd0);
    reqI = 1'b1;
    reqDataI = 32'hC0DE_0003;
    tick();
    reqI = 1'b0;
    checkOutput("push+pop level", DW'(levelO), 32'd2);
    checkOutput("push+pop req_o", DW'(reqO), 32'd1);
    checkOutput("push+pop data", reqDataO, 32'hC0DE_0001);
    expQ = {32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    rxDrain(3, 2, "postreset");
    waitIdle("postreset");

    // Pointer wrap: 3*DEPTH+1 words with concurrent producer and random-latency receiver.
    fork
      producer(3 * DEPTH + 1);
      rxDrain(3 * DEPTH + 1, 4, "wrap");
    join
    waitIdle("wrap");
    checkOutput("wrap queue empty", 32'(expQ.size()), 32'd0);

    // Stalled handshake: timeout only when the feature is built, sticky until reset.
    reqI = 1'b1;
    reqDataI = 32'h7777_0001;
    tick();
    reqI = 1'b0;
    tick();
    checkOutput("stall req_o", DW'(reqO), 32'd1);
    repeat (TIMEOUT - 1) tick();
    checkOutput("timeout before limit", DW'(timeoutO), 32'd0);
    tick();
    checkOutput("timeout at limit", DW'(timeoutO), DW'(TO_EN));
    checkOutput("stall still requesting", DW'(reqO), 32'd1);
    expQ = {32'h7777_0001};
    rxDrain(1, 1, "stall");
    waitIdle("stall");
    checkOutput("timeout sticky", DW'(timeoutO), DW'(TO_EN));
    doReset();
    checkOutput("timeout cleared by reset", DW'(timeoutO), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
